// File: rtl/rx_ds_char_decoder.sv
// DS receive character decoder: assembles header/payload bit-pairs into N-chars and L-chars,
// with optional ESC decoding. Define RX_DS_CHAR_PARITY_EN to enable odd-parity checking.
module rx_ds_char_decoder #(
  parameter int DATA_BITS  = 8,
  parameter int ESC_DECODE = 1
) (
  input  logic                 rxClk,
  input  logic                 rxReset,
  input  logic [1:0]           d,
  input  logic                 dValid,
  output logic [DATA_BITS-1:0] q,
  output logic                 nchar,
  output logic                 lchar,
  output logic                 nullChar,
  output logic                 tick,
  output logic                 parityError,
  output logic                 escError
);

  localparam int NPAIRS = DATA_BITS / 2;
  localparam int CW     = (NPAIRS > 1) ? $clog2(NPAIRS) : 1;
  localparam logic [CW-1:0] LAST_PAIR = CW'(NPAIRS - 1);

  typedef enum logic [1:0] {S_HDR, S_NDATA, S_LDATA, S_HALT} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] q_q, q_d;
  logic [DATA_BITS-1:0] word;
  logic                 esc_pend_q, esc_pend_d;
  logic                 nchar_q, nchar_d, lchar_q, lchar_d;
  logic                 null_q, null_d, tick_q, tick_d;
  logic                 perr_q, perr_d, eerr_q, eerr_d;
  logic                 par_bad, esc_bad;

`ifdef RX_DS_CHAR_PARITY_EN
  // Running parity of the current char's payload; it still holds the previous
  // char's bits when the next header arrives, which is exactly what P covers.
  logic par_acc_q;

  always_ff @(posedge rxClk) begin
    if (rxReset) begin
      par_acc_q <= 1'b0;
    end else if (dValid) begin
      case (state_q)
        S_HDR:            par_acc_q <= 1'b0;
        S_NDATA, S_LDATA: par_acc_q <= par_acc_q ^ d[1] ^ d[0];
        default:          par_acc_q <= par_acc_q;
      endcase
    end
  end

  assign par_bad = dValid && (state_q == S_HDR) && !(par_acc_q ^ d[1] ^ d[0]);
`else
  assign par_bad = 1'b0;
`endif

  assign esc_bad = (ESC_DECODE != 0) && esc_pend_q && dValid &&
                   (state_q == S_LDATA) && (d != 2'b00);

  always_ff @(posedge rxClk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rxReset) begin
      state_q    <= S_HDR;
      cnt_q      <= '0;
      shift_q    <= '0;
      q_q        <= '0;
      esc_pend_q <= 1'b0;
      nchar_q    <= 1'b0;
      lchar_q    <= 1'b0;
      null_q     <= 1'b0;
      tick_q     <= 1'b0;
      perr_q     <= 1'b0;
      eerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      q_q        <= q_d;
      esc_pend_q <= esc_pend_d;
      nchar_q    <= nchar_d;
      lchar_q    <= lchar_d;
      null_q     <= null_d;
      tick_q     <= tick_d;
      perr_q     <= perr_d;
      eerr_q     <= eerr_d;
    end
  end

  always_comb begin
    // NOTE: default first so no path leaves state_d unassigned (no latch).
    state_d = state_q;
    if (dValid) begin
      case (state_q)
        S_HDR:   state_d = par_bad ? S_HALT : (d[1] ? S_LDATA : S_NDATA);
        S_NDATA: if (cnt_q == LAST_PAIR) state_d = S_HDR;
        S_LDATA: state_d = esc_bad ? S_HALT : S_HDR;
        default: state_d = S_HALT;
      endcase
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    q_d        = q_q;
    esc_pend_d = esc_pend_q;
    nchar_d    = 1'b0;
    lchar_d    = 1'b0;
    null_d     = 1'b0;
    tick_d     = 1'b0;
    perr_d     = perr_q | par_bad;
    eerr_d     = eerr_q | esc_bad;
    word       = shift_q;
    word[{cnt_q, 1'b0} +: 2] = d;

    if (dValid) begin
      case (state_q)
        S_HDR: cnt_d = '0;
        S_NDATA: begin
          shift_d = word;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_PAIR) begin
            q_d        = word;
            esc_pend_d = 1'b0;
            if ((ESC_DECODE != 0) && esc_pend_q) tick_d  = 1'b1;
            else                                 nchar_d = 1'b1;
          end
        end
        S_LDATA: begin
          esc_pend_d = 1'b0;
          if ((ESC_DECODE != 0) && esc_pend_q) begin
            null_d = (d == 2'b00);
          end else if ((ESC_DECODE != 0) && (d == 2'b11)) begin
            esc_pend_d = 1'b1;
          end else begin
            lchar_d  = 1'b1;
            q_d      = '0;
            q_d[1:0] = d;
          end
        end
        default: ;
      endcase
    end
  end

  assign q           = q_q;
  assign nchar       = nchar_q;
  assign lchar       = lchar_q;
  assign nullChar    = null_q;
  assign tick        = tick_q;
  assign parityError = perr_q;
  assign escError    = eerr_q;

endmodule
